// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue: FIFO of retiring (rd, data) results drained onto the register bank write port,
// with two forwarding lookups that expose pending writes to operand reads.
module regfile_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [AW-1:0] in_rd,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    input  logic          drain_en,
    output logic          W_en,
    output logic [AW-1:0] RS3,
    output logic [DW-1:0] W_Data,
    input  logic [AW-1:0] fwd_addr1,
    output logic          fwd_hit1,
    output logic [DW-1:0] fwd_data1,
    input  logic [AW-1:0] fwd_addr2,
    output logic          fwd_hit2,
    output logic [DW-1:0] fwd_data2,
    output logic [AW-1:0] count,
    output logic          empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] rd_mem   [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic [PW-1:0] head, tail;
    logic [AW-1:0] cnt;
    logic          pop, push;

    assign empty    = cnt == '0;
    assign count    = cnt;
    assign pop      = drain_en && !empty;
    assign in_ready = (cnt < AW'(DEPTH)) || pop;
    assign push     = in_valid && in_ready && (in_rd != '0);
    assign W_en     = pop;
    assign RS3      = pop ? rd_mem[head] : '0;
    assign W_Data   = pop ? data_mem[head] : '0;

    // Scan oldest to youngest so the last match left standing is the youngest.
    function automatic logic [DW:0] lookup(input logic [AW-1:0] a);
        logic [DW:0]   r;
        logic [PW-1:0] idx;
        r = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (i < int'(cnt) && a != '0 && rd_mem[idx] == a) r = {1'b1, data_mem[idx]};
        end
        return r;
    endfunction

    always_comb begin
        {fwd_hit1, fwd_data1} = lookup(fwd_addr1);
        {fwd_hit2, fwd_data2} = lookup(fwd_addr2);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[tail]   <= in_rd;
            data_mem[tail] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            head <= pop ? head + 1'b1 : head;
            tail <= push ? tail + 1'b1 : tail;
            cnt  <= (push && !pop) ? cnt + 1'b1 : (pop && !push) ? cnt - 1'b1 : cnt;
        end
    end
endmodule

// File: tb/tb_regfile_writeback_queue.sv
// tb_regfile_writeback_queue: queue-model reference bench with directed scenarios and random traffic.
module tb_regfile_writeback_queue;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;

    logic        clk = 0, rst = 0;
    logic        in_valid = 0, drain_en = 0;
    logic [4:0]  in_rd = 0, fwd_addr1 = 0, fwd_addr2 = 0;
    logic [31:0] in_data = 0;
    logic        in_ready, W_en, fwd_hit1, fwd_hit2, empty;
    logic [4:0]  RS3, count;
    logic [31:0] W_Data, fwd_data1, fwd_data2;

    int   errors = 0, checks = 0;
    ent_t q[$];
    ent_t dut_log[$];

    regfile_writeback_queue #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_rd(in_rd), .in_data(in_data),
        .in_ready(in_ready), .drain_en(drain_en), .W_en(W_en), .RS3(RS3), .W_Data(W_Data),
        .fwd_addr1(fwd_addr1), .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
        .fwd_addr2(fwd_addr2), .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic logic [32:0] mfwd(input logic [4:0] a);
        logic [32:0] r = '0;
        if (a != 0) foreach (q[i]) if (q[i].rd == a) r = {1'b1, q[i].d};
        return r;
    endfunction

    // Reference model: a plain queue of pending writes, cleared by reset.
    always @(posedge clk or negedge rst) begin
        if (!rst) q.delete();
        else begin
            automatic bit p  = drain_en && q.size() > 0;
            automatic bit rd = q.size() < DEPTH || p;
            automatic bit ps = in_valid && rd && in_rd != 0;
            if (p) void'(q.pop_front());
            if (ps) q.push_back('{in_rd, in_data});
        end
    end

    always @(negedge clk) begin
        automatic bit   p;
        automatic ent_t h = '0;
        #2;
        if (W_en) dut_log.push_back('{RS3, W_Data});
        p = drain_en && q.size() > 0;
        if (p) h = q[0];
        chk("w_en", W_en, p);
        chk("rs3", RS3, h.rd);
        chk("w_data", W_Data, h.d);
        chk("in_ready", in_ready, q.size() < DEPTH || p);
        chk("count", count, q.size());
        chk("empty", empty, q.size() == 0);
        chk("fwd1", {fwd_hit1, fwd_data1}, mfwd(fwd_addr1));
        chk("fwd2", {fwd_hit2, fwd_data2}, mfwd(fwd_addr2));
    end

    task automatic drive(input logic v, input logic [4:0] r, input logic [31:0] d, input logic de);
        @(negedge clk);
        in_valid = v; in_rd = r; in_data = d; drain_en = de;
        #3;
    endtask

    task automatic chk_log(input int idx, input logic [4:0] r, input logic [31:0] d);
        if (idx < dut_log.size()) chk($sformatf("log%0d", idx), dut_log[idx], {r, d});
        else chk($sformatf("log%0d_missing", idx), dut_log.size(), idx + 1);
    endtask

    initial begin
        #1;
        chk("rst_w_en", W_en, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_ready", in_ready, 1);
        @(negedge clk); rst = 1;
        // Single pass-through
        drive(1, 5, 32'hDEADBEEF, 1);
        chk("pt_pre_wen", W_en, 0);
        drive(0, 0, 0, 1);
        chk("pt_wen", W_en, 1);
        chk("pt_rs3", RS3, 5);
        chk("pt_wdata", W_Data, 32'hDEADBEEF);
        drive(0, 0, 0, 1);
        chk("pt_after_wen", W_en, 0);
        chk("pt_after_cnt", count, 0);
        // Fill and back-pressure
        dut_log.delete();
        for (int i = 1; i <= 4; i++) drive(1, 5'(i), 32'(i * 'h11), 0);
        drive(1, 5, 32'h55, 0);
        chk("full_cnt", count, 4);
        chk("full_ready", in_ready, 0);
        drive(1, 5, 32'h55, 1);
        chk("full_pop_ready", in_ready, 1);
        chk("full_pop_rs3", RS3, 1);
        drive(0, 0, 0, 1);
        chk("full_cnt_kept", count, 4);
        chk("full_rs3_2", RS3, 2);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 1);
        chk("full_log_len", dut_log.size(), 5);
        for (int i = 0; i < 5; i++) chk_log(i, 5'(i + 1), 32'((i + 1) * 'h11));
        // x0 drop
        dut_log.delete();
        fwd_addr1 = 0;
        drive(1, 0, 32'h1234, 0);
        chk("x0_ready", in_ready, 1);
        chk("x0_hit", fwd_hit1, 0);
        drive(0, 0, 0, 1);
        chk("x0_cnt", count, 0);
        drive(0, 0, 0, 1);
        chk("x0_no_write", dut_log.size(), 0);
        // Forwarding youngest
        drive(1, 7, 32'hA, 0);
        drive(1, 7, 32'hB, 0);
        drive(1, 9, 32'hC, 0);
        fwd_addr1 = 7; fwd_addr2 = 9;
        drive(0, 0, 0, 0);
        chk("fwd1_young", {fwd_hit1, fwd_data1}, {1'b1, 32'hB});
        chk("fwd2_hit", {fwd_hit2, fwd_data2}, {1'b1, 32'hC});
        fwd_addr1 = 8; #1;
        chk("fwd1_miss", {fwd_hit1, fwd_data1}, 33'd0);
        dut_log.delete();
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 1);
        chk("fwd_log_len", dut_log.size(), 3);
        chk_log(0, 7, 32'hA);
        chk_log(1, 7, 32'hB);
        chk_log(2, 9, 32'hC);
        // Simultaneous push/pop at count 1
        dut_log.delete();
        for (int i = 0; i < 10; i++) begin
            drive(1, 3, 32'(100 + i), 1);
            if (i > 0) begin
                chk("pp_cnt", count, 1);
                chk("pp_wdata", W_Data, 32'(99 + i));
            end
        end
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        chk("pp_log_len", dut_log.size(), 10);
        for (int i = 0; i < 10; i++) chk_log(i, 3, 32'(100 + i));
        // Reset mid-run with 3 queued
        for (int i = 0; i < 3; i++) drive(1, 5'(10 + i), 32'(i), 0);
        @(negedge clk);
        in_valid = 0; drain_en = 1; rst = 0;
        #1;
        chk("mr_wen", W_en, 0);
        chk("mr_cnt", count, 0);
        chk("mr_empty", empty, 1);
        chk("mr_ready", in_ready, 1);
        @(negedge clk); rst = 1;
        dut_log.delete();
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1);
        chk("mr_no_write", dut_log.size(), 0);
        // Random traffic
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            in_valid  = $urandom_range(0, 9) < 7;
            in_rd     = 5'($urandom_range(0, 7));
            in_data   = $urandom;
            drain_en  = $urandom_range(0, 1) == 1;
            fwd_addr1 = 5'($urandom_range(0, 7));
            fwd_addr2 = 5'($urandom_range(0, 7));
        end
        drive(0, 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule
